// File: rtl/rns_to_bin.sv
// rns_to_bin
//   Sequential mixed-radix converter from a packed 4-channel RNS word to a
//   32-bit binary integer. A word is accepted in IDLE and converted in three
//   MRC steps and three Horner steps. The result register is loaded on the
//   last Horner step, and out_valid is raised on the edge that enters DONE.
//   The result then sits in DONE until the consumer takes it.
//
//   Optional feature macro: RNS_SIGNED_OUT_EN
//     When defined, results of ceil(M/2) or more are returned as value - M,
//     which gives a symmetric signed range. The correction is folded into the
//     last Horner step.
//
//   Ports
//     clk        clock
//     reset      synchronous, active-high reset
//     in_valid   in_rns carries a word
//     in_ready   converter idle, word will be taken on this edge
//     in_rns     packed residues {r3,r2,r1,r0}, 8 bits each
//     out_valid  out_bin/out_err hold a result
//     out_ready  consumer takes the result
//     out_bin    converted value
//     out_err    some input residue was >= its modulus
`default_nettype none

`ifndef B0
`define B0 256
`endif
`ifndef B1
`define B1 255
`endif
`ifndef B2
`define B2 253
`endif
`ifndef B3
`define B3 251
`endif

module rns_to_bin #(
    parameter int M0 = `B0,
    parameter int M1 = `B1,
    parameter int M2 = `B2,
    parameter int M3 = `B3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_rns,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_bin,
    output logic        out_err
);

    function automatic int modOf(input int i);
        case (i)
            0:       return M0;
            1:       return M1;
            2:       return M2;
            default: return M3;
        endcase
    endfunction

    function automatic int gcd(input int a, input int b);
        int x;
        int y;
        int t;
        x = a;
        y = b;
        for (int k = 0; k < 64; k++) begin
            if (y != 0) begin
                t = x % y;
                x = y;
                y = t;
            end
        end
        return x;
    endfunction

    // Brute-force inverse is fine at elaboration: moduli never exceed 256.
    function automatic int modInv(input int a, input int m);
        int r;
        r = 0;
        for (int x = 1; x < 257; x++) begin
            if (r == 0 && x < m && ((a * x) % m) == 1) r = x;
        end
        return r;
    endfunction

    localparam longint MPROD = longint'(M0) * longint'(M1) * longint'(M2) * longint'(M3);

    if (M0 < 2 || M0 > 256 || M1 < 2 || M1 > 256 ||
        M2 < 2 || M2 > 256 || M3 < 2 || M3 > 256) begin : g_badRange
        $error("rns_to_bin: every modulus must lie in 2..256");
    end
    if (gcd(M0, M1) != 1 || gcd(M0, M2) != 1 || gcd(M0, M3) != 1 ||
        gcd(M1, M2) != 1 || gcd(M1, M3) != 1 || gcd(M2, M3) != 1) begin : g_badCoprime
        $error("rns_to_bin: moduli must be pairwise coprime");
    end
    if (MPROD > 64'd4294967295) begin : g_badRange32
        $error("rns_to_bin: product of moduli must be below 2^32");
    end

    typedef enum logic [1:0] {IDLE, MRC, HORNER, DONE} state_t;

    state_t          r_state;
    logic [1:0]      r_step;
    logic [3:0][7:0] r_w;
    logic [31:0]     r_acc;
    logic [31:0]     r_outBin;
    logic            r_outErr;
    logic            r_inReady;
    logic            r_outValid;

    logic [3:0][7:0] w_cap;
    logic [3:0]      w_bad;
    logic [3:1][7:0] w_mrc;
    logic [31:0]     w_hMul;
    logic [31:0]     w_hRad;
    logic [7:0]      w_hDig;
    logic [31:0]     w_hNext;
    logic [31:0]     w_final;

    // Input reduction: residues are folded into range and out-of-range ones flagged.
    for (genvar i = 0; i < 4; i++) begin : g_cap
        localparam int MI = modOf(i);
        assign w_cap[i] = 8'(32'(in_rns[8*i +: 8]) % 32'(MI));
        assign w_bad[i] = 32'(in_rns[8*i +: 8]) >= 32'(MI);
    end

    // One MRC lane per upper digit. The subtracted digit is reduced mod Mj first,
    // so the single +Mj correction is always enough even when Ms > Mj.
    for (genvar j = 1; j < 4; j++) begin : g_mrc
        localparam int         MJ   = modOf(j);
        localparam logic [15:0] INV0 = 16'(modInv(M0 % MJ, MJ));
        localparam logic [15:0] INV1 = 16'(modInv(M1 % MJ, MJ));
        localparam logic [15:0] INV2 = 16'(modInv(M2 % MJ, MJ));

        logic [7:0]  w_ws;
        logic [15:0] w_inv;
        logic [8:0]  w_wsMod;
        logic [8:0]  w_diff;
        logic [8:0]  w_fix;
        logic [15:0] w_prod;

        always_comb begin
            w_ws  = r_w[0];
            w_inv = INV0;
            case (r_step)
                2'd1: begin
                    w_ws  = r_w[1];
                    w_inv = INV1;
                end
                2'd2: begin
                    w_ws  = r_w[2];
                    w_inv = INV2;
                end
                default: ;
            endcase
        end

        assign w_wsMod  = 9'(32'(w_ws) % 32'(MJ));
        assign w_diff   = {1'b0, r_w[j]} - w_wsMod;
        assign w_fix    = w_diff[8] ? w_diff + 9'(MJ) : w_diff;
        assign w_prod   = 16'(w_fix) * w_inv;
        assign w_mrc[j] = 8'(32'(w_prod) % 32'(MJ));
    end

    // Horner step select. The first step reads a3 straight from the digit
    // register, which stands in for loading the accumulator with a3.
    always_comb begin
        w_hMul = r_acc;
        w_hRad = 32'(M0);
        w_hDig = r_w[0];
        case (r_step)
            2'd0: begin
                w_hMul = 32'(r_w[3]);
                w_hRad = 32'(M2);
                w_hDig = r_w[2];
            end
            2'd1: begin
                w_hRad = 32'(M1);
                w_hDig = r_w[1];
            end
            default: ;
        endcase
        w_hNext = w_hMul * w_hRad + 32'(w_hDig);
    end

`ifdef RNS_SIGNED_OUT_EN
    localparam logic [31:0] MMOD  = 32'(MPROD);
    localparam logic [31:0] MHALF = 32'((MPROD + 1) / 2);
    assign w_final = (w_hNext >= MHALF) ? (w_hNext - MMOD) : w_hNext;
`else
    assign w_final = w_hNext;
`endif

    // Control FSM: all outputs registered. Reset drops any conversion in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_step     <= 2'd0;
            r_w        <= '0;
            r_acc      <= '0;
            r_outBin   <= '0;
            r_outErr   <= 1'b0;
            r_inReady  <= 1'b1;
            r_outValid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_w       <= w_cap;
                        r_outErr  <= |w_bad;
                        r_step    <= 2'd0;
                        r_inReady <= 1'b0;
                        r_state   <= MRC;
                    end
                end
                MRC: begin
                    for (int j = 1; j < 4; j++) begin
                        if (j > int'(r_step)) r_w[j] <= w_mrc[j];
                    end
                    if (r_step == 2'd2) begin
                        r_step  <= 2'd0;
                        r_state <= HORNER;
                    end else begin
                        r_step <= r_step + 2'd1;
                    end
                end
                HORNER: begin
                    if (r_step == 2'd3) begin
                        r_step     <= 2'd0;
                        r_outValid <= 1'b1;
                        r_state    <= DONE;
                    end else begin
                        r_acc <= w_hNext;
                        if (r_step == 2'd2) r_outBin <= w_final;
                        r_step <= r_step + 2'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_outValid <= 1'b0;
                        r_inReady  <= 1'b1;
                        r_state    <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = r_inReady;
    assign out_valid = r_outValid;
    assign out_bin   = r_outBin;
    assign out_err   = r_outErr;

endmodule

`default_nettype wire

// File: tb/tb_rns_to_bin.sv
// tb_rns_to_bin
//   Scoreboard bench for rns_to_bin with moduli 256/255/253/251.
//   Expected values come from the integer that was encoded, not from MRC.
module tb_rns_to_bin;

   localparam int     M0 = 256;
   localparam int     M1 = 255;
   localparam int     M2 = 253;
   localparam int     M3 = 251;
   localparam longint MM = 64'd4145475840;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_rns;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_bin;
   logic        out_err;

   logic [31:0] binQ[$];
   logic        errQ[$];
   int          acceptQ[$];

   int cyc = 0;
   int nChecks = 0;
   int nFails = 0;
   bit prevValid = 1'b0;
   bit hsPending = 1'b0;

   rns_to_bin #(.M0(M0), .M1(M1), .M2(M2), .M3(M3)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_rns    (in_rns),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_bin   (out_bin),
      .out_err   (out_err)
   );

   // Free-running clock and edge counter used for latency measurement.
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Hard stop in case the stimulus itself gets stuck.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      nChecks++;
      if (actual !== expected) begin
         nFails++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
      end
   endtask

   function automatic logic [31:0] packRes(input longint v);
      return {8'(v % M3), 8'(v % M2), 8'(v % M1), 8'(v % M0)};
   endfunction

   function automatic logic [31:0] expectBin(input longint v);
`ifdef RNS_SIGNED_OUT_EN
      if (v >= (MM + 1) / 2) return 32'(v - MM);
`endif
      return 32'(v);
   endfunction

   // Drive one word once the converter is idle and log its expectation.
   task automatic applyStimulus(input logic [31:0] word, input logic [31:0] expBin, input logic expErr);
      int n = 0;
      @(posedge clk); #1;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) begin
         checkOutput("accept_timeout", 32'(in_ready), 32'd1);
         return;
      end
      in_valid = 1'b1;
      in_rns   = word;
      binQ.push_back(expBin);
      errQ.push_back(expErr);
      acceptQ.push_back(cyc + 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_rns   = $urandom;
   endtask

   task automatic waitDrain();
      int n = 0;
      while (binQ.size() != 0 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput("drain_timeout", 32'(binQ.size()), 32'd0);
   endtask

   // Output monitor: latency on the first valid cycle, data every valid cycle,
   // pop on handshake, and idle state right after each handshake.
   always @(negedge clk) begin
      if (reset) begin
         prevValid <= 1'b0;
         hsPending <= 1'b0;
      end else begin
         if (hsPending) begin
            checkOutput("post_hs_ready", 32'(in_ready), 32'd1);
            checkOutput("post_hs_valid", 32'(out_valid), 32'd0);
         end
         hsPending <= out_valid && out_ready;
         if (out_valid) begin
            if (!prevValid) begin
               if (acceptQ.size() == 0) checkOutput("spurious_valid", 32'(out_valid), 32'd0);
               else checkOutput("latency", 32'(cyc - acceptQ.pop_front()), 32'd7);
            end
            if (binQ.size() == 0) begin
               checkOutput("unexpected_valid", 32'(out_valid), 32'd0);
            end else begin
               checkOutput("bin", out_bin, binQ[0]);
               checkOutput("err", 32'(out_err), 32'(errQ[0]));
               checkOutput("busy_ready", 32'(in_ready), 32'd0);
               if (out_ready) begin
                  void'(binQ.pop_front());
                  void'(errQ.pop_front());
               end
            end
            prevValid <= !out_ready;
         end else begin
            prevValid <= 1'b0;
         end
      end
   end

   initial begin
      longint vals [5];
      longint v;
      int n;

      reset     = 1'b1;
      in_valid  = 1'b0;
      in_rns    = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_out_bin", out_bin, 32'd0);
      checkOutput("rst_out_err", 32'(out_err), 32'd0);

      // Directed words.
      applyStimulus(32'hF7F1EBE8, 32'd1000, 1'b0);
      waitDrain();
      applyStimulus(32'h00000000, 32'd0, 1'b0);
      waitDrain();
      applyStimulus(32'hFAFCFEFF, expectBin(MM - 1), 1'b0);
      waitDrain();
      applyStimulus(32'h0000FF00, 32'd0, 1'b1);
      waitDrain();

      // Backpressure: result must stay put while the consumer stalls.
      out_ready = 1'b0;
      applyStimulus(packRes(64'd123456789), expectBin(64'd123456789), 1'b0);
      n = 0;
      while (!out_valid && n < 30) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput("bp_valid", 32'(out_valid), 32'd1);
      repeat (10) begin
         @(posedge clk); #1;
         checkOutput("bp_hold", 32'(out_valid), 32'd1);
         checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      waitDrain();

      // Back-to-back stream with the consumer always ready.
      repeat (4) applyStimulus(32'hF7F1EBE8, 32'd1000, 1'b0);
      waitDrain();

      // Boundary and random values.
      vals = '{MM / 2 - 1, MM / 2, 64'd1, MM - 2, 64'd12345678};
      foreach (vals[i]) applyStimulus(packRes(vals[i]), expectBin(vals[i]), 1'b0);
      for (int k = 0; k < 4; k++) begin
         v = longint'($urandom) % MM;
         applyStimulus(packRes(v), expectBin(v), 1'b0);
      end
      waitDrain();

      // Reset three edges after acceptance discards the word in flight.
      applyStimulus(32'hF7F1EBE8, 32'd1000, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      binQ.delete();
      errQ.delete();
      acceptQ.delete();
      checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
      checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
      repeat (10) begin
         @(posedge clk); #1;
         checkOutput("midrst_quiet", 32'(out_valid), 32'd0);
      end
      applyStimulus(32'hF7F1EBE8, 32'd1000, 1'b0);
      waitDrain();

      repeat (3) @(posedge clk);
      #1;
      checkOutput("final_queue", 32'(acceptQ.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
      $finish;
   end

endmodule
